// File: rtl/spi_if.sv
// spi_if: host-side word handshake plus the four SPI wires.
// master = the controller, slave = the host/peripheral side.
interface spi_if #(
    parameter int WIDTH = 8
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             busy;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             sclk;
    logic             sdo;
    logic             cs_n;
    logic             sdi;

    modport master (
        input  tx_valid, tx_data, sdi,
        output tx_ready, busy, rx_data, rx_valid,
        output sclk, sdo, cs_n
    );

    modport slave (
        output tx_valid, tx_data, sdi,
        input  tx_ready, busy, rx_data, rx_valid,
        input  sclk, sdo, cs_n
    );
endinterface

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master, one WIDTH-bit word per cs_n frame.
// Every output is a register; phase timing comes from a reloading divider.
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int WIDTH   = 8
) (
    input  logic  clk,
    input  logic  reset,
    spi_if.master bus
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST   = BW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;

    logic             tick;
    logic [WIDTH-1:0] tx_shift;

    assign tick     = (cnt_q == '0);
    assign tx_shift = tx_sh_q << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            sdo_q      <= sdo_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        sdo_d      = sdo_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        tx_ready_d = tx_ready_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (bus.tx_valid && tx_ready_q) begin
                    state_d    = SETUP;
                    tx_sh_d    = bus.tx_data;
                    sdo_d      = bus.tx_data[WIDTH-1];
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                    cnt_d      = RELOAD;
                    bit_d      = '0;
                end
            end
            SETUP: begin
                cnt_d = cnt_q - CW'(1);
                if (tick) begin
                    state_d    = XFER;
                    cnt_d      = RELOAD;
                    sclk_d     = 1'b1;
                    rx_sh_d    = rx_sh_q << 1;
                    rx_sh_d[0] = bus.sdi;
                    bit_d      = bit_q + BW'(1);
                end
            end
            XFER: begin
                cnt_d = cnt_q - CW'(1);
                if (tick) begin
                    cnt_d = RELOAD;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // sdo stays on the final bit through HOLD
                        if (bit_q == LAST) begin
                            state_d = HOLD;
                        end else begin
                            tx_sh_d = tx_shift;
                            sdo_d   = tx_shift[WIDTH-1];
                        end
                    end else begin
                        sclk_d     = 1'b1;
                        rx_sh_d    = rx_sh_q << 1;
                        rx_sh_d[0] = bus.sdi;
                        bit_d      = bit_q + BW'(1);
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q - CW'(1);
                if (tick) begin
                    state_d    = GAP;
                    cnt_d      = RELOAD;
                    cs_n_d     = 1'b1;
                    sdo_d      = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                end
            end
            GAP: begin
                cnt_d = cnt_q - CW'(1);
                if (tick) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    busy_d     = 1'b0;
                    tx_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sclk     = sclk_q;
    assign bus.sdo      = sdo_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.busy     = busy_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: random and directed frames checked against
// a cycle-position model of the mode-0 frame.
module tb_spi_controller;
    localparam int D  = 2;
    localparam int W  = 8;
    localparam int D2 = 3;
    localparam int W2 = 1;

    logic clk = 1'b0;
    logic reset;
    logic loop_en;
    logic sdi_drv;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_if #(.WIDTH(W))  a_if ();
    spi_if #(.WIDTH(W2)) b_if ();

    assign a_if.sdi = loop_en ? a_if.sdo : sdi_drv;

    spi_controller #(.CLK_DIV(D), .WIDTH(W)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    spi_controller #(.CLK_DIV(D2), .WIDTH(W2)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle c counts from the handshake cycle (c=0).
    function automatic int lo_len(int w, int d);
        return 2 * w * d + d;
    endfunction

    function automatic bit e_sclk(int c, int w, int d);
        int p;
        if (c <= d || c > lo_len(w, d)) return 1'b0;
        p = (c - d - 1) / d;
        return (p % 2) == 0;
    endfunction

    function automatic int e_sdo_idx(int c, int w, int d);
        int f;
        if (c <= d) return w - 1;
        f = ((c - d - 1) / d + 1) / 2;
        if (f > w - 1) f = w - 1;
        return w - 1 - f;
    endfunction

    function automatic int rise_idx(int c, int w, int d);
        int k;
        if (c < 1) return 0;
        k = (c - 1) / (2 * d);
        if (k > w - 1) k = w - 1;
        return k;
    endfunction

    task automatic start_a(input logic [W-1:0] word);
        int t;
        t = 0;
        @(negedge clk);
        while (!a_if.tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("a_ready_wait", a_if.tx_ready, 1);
        a_if.tx_valid = 1'b1;
        a_if.tx_data  = word;
    endtask

    task automatic xfer_a(input logic [W-1:0] word, input logic [W-1:0] resp,
                          input bit loop, input bit keep,
                          input logic [W-1:0] nxt, input bit poke);
        int L;
        logic [W-1:0] exp_rx;
        L = lo_len(W, D);
        exp_rx = loop ? word : resp;
        loop_en = loop;
        for (int c = 1; c <= L + D + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_if.tx_valid = keep;
                a_if.tx_data  = keep ? nxt : ~word;
            end
            if (poke && c == D + 5) begin
                a_if.tx_valid = 1'b1;
                a_if.tx_data  = ~word;
            end
            if (poke && c == D + 6) a_if.tx_valid = 1'b0;
            sdi_drv = resp[W - 1 - rise_idx(c, W, D)];
            check("a_cs_n", a_if.cs_n, (c <= L) ? 0 : 1);
            check("a_sclk", a_if.sclk, e_sclk(c, W, D));
            check("a_sdo", a_if.sdo, (c <= L) ? word[e_sdo_idx(c, W, D)] : 1'b0);
            check("a_rx_valid", a_if.rx_valid, (c == L + 1) ? 1 : 0);
            check("a_busy", a_if.busy, (c <= L + D) ? 1 : 0);
            check("a_tx_ready", a_if.tx_ready, (c == L + D + 1) ? 1 : 0);
            if (c == L + 1) check("a_rx_data", a_if.rx_data, exp_rx);
        end
    endtask

    task automatic xfer_b(input logic bval, input logic dval);
        int L;
        int t;
        int rises;
        logic prev;
        L = lo_len(W2, D2);
        t = 0;
        rises = 0;
        prev = 1'b0;
        @(negedge clk);
        while (!b_if.tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("b_ready_wait", b_if.tx_ready, 1);
        b_if.tx_valid = 1'b1;
        b_if.tx_data  = dval;
        b_if.sdi      = ~bval;
        for (int c = 1; c <= L + D2 + 1; c++) begin
            @(negedge clk);
            b_if.tx_valid = 1'b0;
            b_if.sdi = (c == D2) ? bval : ~bval;
            if (b_if.sclk && !prev) rises++;
            prev = b_if.sclk;
            check("b_cs_n", b_if.cs_n, (c <= L) ? 0 : 1);
            check("b_sclk", b_if.sclk, e_sclk(c, W2, D2));
            check("b_sdo", b_if.sdo, (c <= L) ? dval : 1'b0);
            check("b_rx_valid", b_if.rx_valid, (c == L + 1) ? 1 : 0);
            check("b_tx_ready", b_if.tx_ready, (c == L + D2 + 1) ? 1 : 0);
            if (c == L + 1) check("b_rx_data", b_if.rx_data, bval);
        end
        check("b_rise_count", rises, 1);
    endtask

    logic [W-1:0] w0;
    logic [W-1:0] r0;
    int pulses;

    initial begin
        reset = 1'b1;
        loop_en = 1'b0;
        sdi_drv = 1'b0;
        a_if.tx_valid = 1'b0;
        a_if.tx_data  = '0;
        b_if.tx_valid = 1'b0;
        b_if.tx_data  = '0;
        b_if.sdi      = 1'b0;

        repeat (2) @(negedge clk);
        a_if.tx_valid = 1'b1;
        a_if.tx_data  = 8'h5A;
        repeat (2) @(negedge clk);
        check("rst_cs_n", a_if.cs_n, 1);
        check("rst_sclk", a_if.sclk, 0);
        check("rst_sdo", a_if.sdo, 0);
        check("rst_tx_ready", a_if.tx_ready, 0);
        check("rst_busy", a_if.busy, 0);
        check("rst_rx_valid", a_if.rx_valid, 0);
        check("rst_rx_data", a_if.rx_data, 0);
        check("rst_b_cs_n", b_if.cs_n, 1);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", a_if.tx_ready, 1);
        check("post_rst_busy", a_if.busy, 0);
        check("post_rst_cs_n", a_if.cs_n, 1);
        a_if.tx_valid = 1'b0;

        start_a(8'hA5);
        xfer_a(8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

        start_a(8'hFF);
        xfer_a(8'hFF, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);

        start_a(8'h01);
        xfer_a(8'h01, W'($urandom), 1'b0, 1'b1, 8'h80, 1'b0);
        xfer_a(8'h80, W'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);

        w0 = W'($urandom);
        start_a(w0);
        xfer_a(w0, W'($urandom), 1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 6; i++) begin
            w0 = W'($urandom);
            r0 = W'($urandom);
            start_a(w0);
            xfer_a(w0, r0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
        end

        w0 = W'($urandom);
        start_a(w0);
        loop_en = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) a_if.tx_valid = 1'b0;
        end
        check("abort_4th_rise", a_if.sclk, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs_n", a_if.cs_n, 1);
        check("abort_sclk", a_if.sclk, 0);
        check("abort_rx_valid", a_if.rx_valid, 0);
        check("abort_busy", a_if.busy, 0);
        check("abort_rx_data", a_if.rx_data, 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", a_if.tx_ready, 1);
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (a_if.rx_valid) pulses++;
        end
        check("abort_no_rx_valid", pulses, 0);

        start_a(8'hC3);
        xfer_a(8'hC3, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

        xfer_b(1'b1, 1'b0);
        xfer_b(1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
